// File: rtl/packet_framer.sv
// Packet framer: turns (stream, length) commands plus a payload word stream into
// header / sequence / payload words, keeping a per-stream sequence counter.
module packet_framer #(
    parameter int unsigned NUM_STREAMS = 16,
    parameter int unsigned MAX_LEN     = 1500
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        cmd_val,
    output logic        cmd_ready,
    input  logic [15:0] cmd_stream,
    input  logic [15:0] cmd_length,
    output logic        cmd_err,
    input  logic [31:0] pay_data,
    input  logic        pay_val,
    output logic        pay_ready,
    output logic [31:0] dataOut,
    output logic        dataOut_val,
    input  logic        dataOut_ready,
    output logic        dataOut_last
);

    localparam int unsigned IDX_W = $clog2(NUM_STREAMS);
    localparam int unsigned WC_W  = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEQ  = 2'd2,
        PAY  = 2'd3
    } state_t;

    state_t state, stateNext;

    logic [IDX_W-1:0] streamIdx;
    logic [1:0]       lenTail;
    logic [WC_W-1:0]  payLeft;
    logic [31:0]      seqLat;
    logic [31:0]      seqTable [NUM_STREAMS];

    logic             cmdFire, cmdLegal, outFire, payFire;
    logic             latchCmd, seqWrite;
    logic [WC_W-1:0]  wordCount;
    logic [IDX_W-1:0] cmdIdx;
    logic [31:0]      hdrWord, seqWord, payMask;
    logic [31:0]      dataOutNext;
    logic             valNext, lastNext, cmdReadyNext, cmdErrNext;

    assign cmdIdx    = cmd_stream[IDX_W-1:0];
    assign cmdFire   = cmd_val && cmd_ready;
    assign cmdLegal  = (cmd_length >= 16'd8) && (cmd_length <= 16'(MAX_LEN));
    assign outFire   = dataOut_val && dataOut_ready;
    assign wordCount = WC_W'((17'(cmd_length) + 17'd3) >> 2);
    assign hdrWord   = {cmd_length[7:0], cmd_length[15:8], cmd_stream[7:0], cmd_stream[15:8]};
    assign seqWord   = {seqLat[7:0], seqLat[15:8], seqLat[23:16], seqLat[31:24]};

    // Payload is pulled only while words remain and the output register can take one.
    assign pay_ready = (state == PAY) && (payLeft != '0) && (!dataOut_val || dataOut_ready);
    assign payFire   = pay_val && pay_ready;

    // Keep only the leading valid bytes of the final payload word.
    always_comb begin
        payMask = 32'hFFFF_FFFF;
        if (payLeft == WC_W'(1)) begin
            case (lenTail)
                2'd1:    payMask = 32'hFF00_0000;
                2'd2:    payMask = 32'hFFFF_0000;
                2'd3:    payMask = 32'hFFFF_FF00;
                default: payMask = 32'hFFFF_FFFF;
            endcase
        end
    end

    // Next-state and next-output-register logic.
    always_comb begin
        stateNext    = state;
        dataOutNext  = dataOut;
        valNext      = dataOut_val;
        lastNext     = dataOut_last;
        cmdErrNext   = 1'b0;
        latchCmd     = 1'b0;
        seqWrite     = 1'b0;

        if (outFire) begin
            valNext  = 1'b0;
            lastNext = 1'b0;
        end

        case (state)
            IDLE: begin
                if (cmdFire) begin
                    if (cmdLegal) begin
                        latchCmd    = 1'b1;
                        stateNext   = HDR;
                        dataOutNext = hdrWord;
                        valNext     = 1'b1;
                        lastNext    = 1'b0;
                    end else begin
                        cmdErrNext  = 1'b1;
                    end
                end
            end
            HDR: begin
                if (outFire) begin
                    stateNext   = SEQ;
                    dataOutNext = seqWord;
                    valNext     = 1'b1;
                    lastNext    = (payLeft == '0);
                end
            end
            SEQ: begin
                if (outFire) begin
                    if (dataOut_last) begin
                        stateNext = IDLE;
                        seqWrite  = 1'b1;
                    end else begin
                        stateNext = PAY;
                    end
                end
            end
            PAY: begin
                if (payFire) begin
                    dataOutNext = pay_data & payMask;
                    valNext     = 1'b1;
                    lastNext    = (payLeft == WC_W'(1));
                end
                if (outFire && dataOut_last) begin
                    stateNext = IDLE;
                    seqWrite  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        // Idle-to-idle only: leaves a one-cycle gap after a packet ends.
        cmdReadyNext = (state == IDLE) && (stateNext == IDLE);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Output register, command context and sequence table.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cmd_ready    <= 1'b0;
            cmd_err      <= 1'b0;
            dataOut      <= '0;
            dataOut_val  <= 1'b0;
            dataOut_last <= 1'b0;
            streamIdx    <= '0;
            lenTail      <= '0;
            payLeft      <= '0;
            seqLat       <= '0;
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                seqTable[i] <= 32'd1;
            end
        end else begin
            cmd_ready    <= cmdReadyNext;
            cmd_err      <= cmdErrNext;
            dataOut      <= dataOutNext;
            dataOut_val  <= valNext;
            dataOut_last <= lastNext;
            if (latchCmd) begin
                streamIdx <= cmdIdx;
                lenTail   <= cmd_length[1:0];
                payLeft   <= wordCount - WC_W'(2);
                seqLat    <= seqTable[cmdIdx];
            end else if (payFire) begin
                payLeft   <= payLeft - WC_W'(1);
            end
            if (seqWrite) begin
                seqTable[streamIdx] <= seqLat + 32'd1;
            end
        end
    end

endmodule
